mc_controller: RTL and testbench

Moore-style control unit for the multicycle RV32I datapath, the successor to the single-cycle ALU decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives all datapath enables and mux selects. ALU decoding is widened by a parameter (3-bit base set or 4-bit extended set). The block sits between the instruction register and the shared-memory multicycle datapath.

---
 rtl/mc_ctrl_pkg.sv | 74 +++++++
 rtl/mc_controller_if.sv | 35 +++
 rtl/mc_controller_alu_decoder_w.sv | 43 ++++
 rtl/mc_controller.sv | 143 ++++++++++++++
 tb/tb_mc_controller.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states,
// opcodes, ALUOp, ALUControl (4-bit, truncated by ALUCTRL_W) and mux selects.
package mc_ctrl_pkg;

    localparam int unsigned OP_W      = 7;
    localparam int unsigned ALU4_W    = 4;
    localparam int unsigned SEL_W     = 2;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [ALU4_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU4_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU4_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [ALU4_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [ALU4_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALU4_W-1:0] ALU_SLT  = 4'b0101;
    localparam logic [ALU4_W-1:0] ALU_SLL  = 4'b0110;
    localparam logic [ALU4_W-1:0] ALU_SRL  = 4'b0111;
    localparam logic [ALU4_W-1:0] ALU_SRA  = 4'b1000;
    localparam logic [ALU4_W-1:0] ALU_SLTU = 4'b1001;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RD2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

    // Immediate format implied by the opcode; formats without an immediate use I.
    function automatic logic [SEL_W-1:0] imm_src_of(input logic [OP_W-1:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control bus between the instruction register/datapath and mc_controller.
// master = controller side, slave = datapath side.
interface mc_controller_if #(
    parameter int unsigned ALUCTRL_W = 3
);
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 Zero;
    logic                 mem_ready;

    logic                 PCWrite;
    logic                 AdrSrc;
    logic                 MemWrite;
    logic                 IRWrite;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ImmSrc;
    logic                 RegWrite;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 illegal;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, RegWrite, ALUControl, illegal
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, RegWrite, ALUControl, illegal
    );
endinterface

// File: rtl/mc_controller_alu_decoder_w.sv
// Combinational ALU decoder: ALUOp + funct fields -> ALUControl.
// ALUCTRL_W=3 keeps the base set; shift/xor/sltu fall back to add.
module alu_decoder_w
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3
) (
    input  aluop_t               alu_op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 op5,
    output logic [ALUCTRL_W-1:0] alu_control
);

    localparam bit EXT = (ALUCTRL_W >= 4);

    logic [ALU4_W-1:0] ctl4;

    // Full 4-bit decode, then truncated to the configured width.
    always_comb begin
        ctl4 = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: ctl4 = ALU_ADD;
            ALUOP_SUB: ctl4 = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ctl4 = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  ctl4 = EXT ? ALU_SLL : ALU_ADD;
                    3'b010:  ctl4 = ALU_SLT;
                    3'b011:  ctl4 = EXT ? ALU_SLTU : ALU_ADD;
                    3'b100:  ctl4 = EXT ? ALU_XOR : ALU_ADD;
                    3'b101:  ctl4 = EXT ? (funct7b5 ? ALU_SRA : ALU_SRL) : ALU_ADD;
                    3'b110:  ctl4 = ALU_OR;
                    default: ctl4 = ALU_AND;
                endcase
            end
            default: ctl4 = ALU_ADD;
        endcase
    end

    assign alu_control = ALUCTRL_W'(ctl4);

endmodule

// File: rtl/mc_controller.sv
// Moore control unit for the multicycle RV32I datapath.
// Optional feature: define MC_CTRL_MEM_WAIT_EN to enable the mem_ready
// handshake (FETCH/MEMREAD/MEMWRITE hold until memory completes).
// Outputs are combinational from state; while reset is high they show
// FETCH values so no write strobe escapes during reset.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
);

    state_t state;
    state_t state_next;
    state_t out_state;
    aluop_t alu_op;
    logic   ready;
    logic   branch;
    logic   pc_update;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign ready = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign ready            = 1'b1;
`endif

    assign out_state = reset ? S_FETCH : state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state controls.
    always_comb begin
        state_next    = state;
        alu_op        = ALUOP_ADD;
        branch        = 1'b0;
        pc_update     = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ResultSrc = RES_ALUOUT;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_RD2;
        bus.illegal   = 1'b0;

        case (state)
            S_FETCH:    if (ready) state_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_BRANCH:         state_next = S_BEQ;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (ready) state_next = S_MEMWB;
            S_MEMWRITE: if (ready) state_next = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_JAL: state_next = S_ALUWB;
            default:    state_next = S_FETCH;
        endcase

        case (out_state)
            S_FETCH: begin
                bus.IRWrite   = ready;
                pc_update     = ready;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                case (bus.op)
                    OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: bus.illegal = 1'b0;
                    default: bus.illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_RD1;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  bus.AdrSrc = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                bus.RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                bus.ALUSrcA = SRCA_RD1;
                alu_op      = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                bus.ALUSrcA = SRCA_RD1;
                bus.ALUSrcB = SRCB_IMM;
                alu_op      = ALUOP_FUNCT;
            end
            S_ALUWB:    bus.RegWrite = 1'b1;
            S_BEQ: begin
                bus.ALUSrcA = SRCA_RD1;
                alu_op      = ALUOP_SUB;
                branch      = 1'b1;
            end
            S_JAL: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                pc_update   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.PCWrite = pc_update | (branch & bus.Zero);
    assign bus.ImmSrc  = imm_src_of(bus.op);

    // ALU operation decode.
    alu_decoder_w #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .op5         (bus.op[5]),
        .alu_control (bus.ALUControl)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: runs a 3-bit and a 4-bit ALUControl instance in
// lockstep. Each instruction is expanded into its list of phases; every
// cycle the expected controls come from the phase's datapath meaning.
module tb_mc_controller;

`ifdef MC_CTRL_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3,
                   ST_MEMWB = 4, ST_MEMWRITE = 5, ST_EXECR = 6, ST_EXECI = 7,
                   ST_ALUWB = 8, ST_BEQ = 9, ST_JAL = 10;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] imm;
        logic       rw;
        logic [3:0] alu4;
        logic [2:0] alu3;
        logic       ill;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zero;
    logic       ready;

    always #5 clk = ~clk;

    mc_controller_if #(.ALUCTRL_W(3)) bus3 ();
    mc_controller_if #(.ALUCTRL_W(4)) bus4 ();

    assign bus3.op = op;  assign bus3.funct3 = f3;  assign bus3.funct7b5 = f7;
    assign bus3.Zero = zero;  assign bus3.mem_ready = ready;
    assign bus4.op = op;  assign bus4.funct3 = f3;  assign bus4.funct7b5 = f7;
    assign bus4.Zero = zero;  assign bus4.mem_ready = ready;

    mc_controller #(.ALUCTRL_W(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
    mc_controller #(.ALUCTRL_W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    // ---------------- reference model ----------------
    function automatic logic [1:0] imm_ref(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [3:0] alu4_ref(input logic [2:0] fn3, input logic fn7, input logic op5);
        case (fn3)
            3'b000:  return (op5 && fn7) ? 4'd1 : 4'd0;
            3'b001:  return 4'd6;
            3'b010:  return 4'd5;
            3'b011:  return 4'd9;
            3'b100:  return 4'd4;
            3'b101:  return fn7 ? 4'd8 : 4'd7;
            3'b110:  return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic [2:0] alu3_ref(input logic [2:0] fn3, input logic fn7, input logic op5);
        case (fn3)
            3'b000:  return (op5 && fn7) ? 3'd1 : 3'd0;
            3'b010:  return 3'd5;
            3'b110:  return 3'd3;
            3'b111:  return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic ctl_t model(input int st, input logic [6:0] o, input logic [2:0] fn3,
                                   input logic fn7, input logic z, input logic rdy);
        ctl_t c;
        c = '0;
        c.imm = imm_ref(o);
        case (st)
            ST_FETCH: begin
                c.sb  = 2'b10;  c.rs = 2'b10;
                c.irw = WAIT_EN ? rdy : 1'b1;
                c.pcw = c.irw;
            end
            ST_DECODE: begin
                c.sa  = 2'b01;  c.sb = 2'b01;
                c.ill = !(o inside {7'b0000011, 7'b0100011, 7'b0110011,
                                    7'b0010011, 7'b1100011, 7'b1101111});
            end
            ST_MEMADR:   begin c.sa = 2'b10; c.sb = 2'b01; end
            ST_MEMREAD:  c.adr = 1'b1;
            ST_MEMWB:    begin c.rs = 2'b01; c.rw = 1'b1; end
            ST_MEMWRITE: begin c.adr = 1'b1; c.mw = 1'b1; end
            ST_EXECR: begin
                c.sa   = 2'b10;
                c.alu4 = alu4_ref(fn3, fn7, o[5]);
                c.alu3 = alu3_ref(fn3, fn7, o[5]);
            end
            ST_EXECI: begin
                c.sa   = 2'b10;  c.sb = 2'b01;
                c.alu4 = alu4_ref(fn3, fn7, o[5]);
                c.alu3 = alu3_ref(fn3, fn7, o[5]);
            end
            ST_ALUWB:    c.rw = 1'b1;
            ST_BEQ: begin
                c.sa   = 2'b10;
                c.alu4 = 4'd1;  c.alu3 = 3'd1;
                c.pcw  = z;
            end
            ST_JAL:      begin c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t pin_of(input logic pcw, adr, mw, irw, input logic [1:0] rs, sa, sb, imm,
                                    input logic rw, input logic [3:0] a4, input logic [2:0] a3, input logic ill);
        ctl_t c;
        c = {pcw, adr, mw, irw, rs, sa, sb, imm, rw, a4, a3, ill};
        return c;
    endfunction

    // ---------------- compare process ----------------
    ctl_t  exp_ctl;
    bit    exp_valid = 1'b0;
    int    exp_step;
    ctl_t  lit_ctl;
    bit    lit_valid = 1'b0;
    string lit_name;
    int    n_checks = 0;
    int    n_fail   = 0;
    ctl_t  g3, g4;

    task automatic check(input string nm, input ctl_t got, input ctl_t want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s step=%0d got=%h want=%h t=%0t", nm, exp_step, got, want, $time);
        end
    endtask

    // Compare both DUTs against the model, and against literal pins where set.
    always @(negedge clk) begin
        if (exp_valid) begin
            g4 = {bus4.PCWrite, bus4.AdrSrc, bus4.MemWrite, bus4.IRWrite, bus4.ResultSrc,
                  bus4.ALUSrcA, bus4.ALUSrcB, bus4.ImmSrc, bus4.RegWrite,
                  bus4.ALUControl, bus3.ALUControl, bus4.illegal};
            g3 = {bus3.PCWrite, bus3.AdrSrc, bus3.MemWrite, bus3.IRWrite, bus3.ResultSrc,
                  bus3.ALUSrcA, bus3.ALUSrcB, bus3.ImmSrc, bus3.RegWrite,
                  bus4.ALUControl, bus3.ALUControl, bus3.illegal};
            check("model_w4", g4, exp_ctl);
            check("model_w3", g3, exp_ctl);
            if (lit_valid) begin
                check({lit_name, "_w4"}, g4, lit_ctl);
                check({lit_name, "_w3"}, g3, lit_ctl);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step_cycle(input int st, input logic rdy, input logic rst,
                              input ctl_t pin, input bit pin_en, input string nm);
        ready     = rdy;
        reset     = rst;
        exp_step  = rst ? ST_FETCH : st;
        exp_ctl   = model(exp_step, op, f3, f7, zero, rdy);
        lit_ctl   = pin;
        lit_valid = pin_en;
        lit_name  = nm;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One instruction; stall<0 picks random wait cycles, abort_at raises reset in that phase.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] fn3, input logic fn7,
                             input logic z, input int stall, input int abort_at,
                             input int pin_at, input ctl_t pin, input string nm);
        int steps[$];
        steps.push_back(ST_FETCH);
        steps.push_back(ST_DECODE);
        case (o)
            7'b0000011: begin steps.push_back(ST_MEMADR); steps.push_back(ST_MEMREAD); steps.push_back(ST_MEMWB); end
            7'b0100011: begin steps.push_back(ST_MEMADR); steps.push_back(ST_MEMWRITE); end
            7'b0110011: begin steps.push_back(ST_EXECR); steps.push_back(ST_ALUWB); end
            7'b0010011: begin steps.push_back(ST_EXECI); steps.push_back(ST_ALUWB); end
            7'b1100011: steps.push_back(ST_BEQ);
            7'b1101111: begin steps.push_back(ST_JAL); steps.push_back(ST_ALUWB); end
            default: ;
        endcase
        op = o;  f3 = fn3;  f7 = fn7;  zero = z;
        for (int i = 0; i < steps.size(); i++) begin
            int st;
            int n_st;
            bit can_stall;
            st        = steps[i];
            can_stall = WAIT_EN && (st == ST_FETCH || st == ST_MEMREAD || st == ST_MEMWRITE);
            n_st      = !can_stall ? 0 : (stall < 0 ? int'($urandom_range(0, 2)) : stall);
            for (int k = 0; k < n_st; k++) step_cycle(st, 1'b0, 1'b0, '0, 1'b0, "");
            if (i == abort_at) begin
                step_cycle(st, 1'b0, 1'b1, '0, 1'b0, "");
                return;
            end
            step_cycle(st, WAIT_EN ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, pin, i == pin_at, nm);
        end
    endtask

    logic [6:0] op_tab [0:5];
    ctl_t       nopin;

    initial begin
        op_tab[0] = 7'b0000011; op_tab[1] = 7'b0100011; op_tab[2] = 7'b0110011;
        op_tab[3] = 7'b0010011; op_tab[4] = 7'b1100011; op_tab[5] = 7'b1101111;
        nopin = '0;
        reset = 1'b1;  op = 7'b0000011;  f3 = 3'b000;  f7 = 1'b0;  zero = 1'b0;  ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held two cycles: FETCH-valued outputs.
        for (int r = 0; r < 2; r++)
            step_cycle(ST_FETCH, 1'b1, 1'b1,
                       pin_of(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 4'd0, 3'd0, 0), 1'b1, "reset");

        // lw: write-back of memory data in the fifth cycle.
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, -1, 4,
                  pin_of(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 4'd0, 3'd0, 0), "lw_memwb");
        // R-type sub: execute then ALU write-back.
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, -1, 2,
                  pin_of(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 4'd1, 3'd1, 0), "sub_exec");
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, -1, 3,
                  pin_of(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4'd0, 3'd0, 0), "sub_aluwb");
        // beq taken / not taken.
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, -1, 2,
                  pin_of(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 4'd1, 3'd1, 0), "beq_taken");
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, -1, 2,
                  pin_of(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 4'd1, 3'd1, 0), "beq_not_taken");
        // srai: sra in the extended set, add in the base set.
        run_instr(7'b0010011, 3'b101, 1'b1, 1'b0, 0, -1, 2,
                  pin_of(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 4'd8, 3'd0, 0), "srai");
        // Unsupported opcode: illegal pulse in DECODE, then FETCH.
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, -1, 1,
                  pin_of(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 4'd0, 3'd0, 1), "illegal");
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, -1, -1, nopin, "");
        // sw with three not-ready cycles in each memory phase.
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 3, -1, 3,
                  pin_of(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 4'd0, 3'd0, 0), "sw_write");
        // sw with reset raised during the MEMWRITE stall.
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 2, 3, -1, nopin, "");
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1, -1, -1, nopin, "");

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            logic [6:0] ro;
            int         idx;
            int         ab;
            idx = int'($urandom_range(0, 6));
            ro  = (idx == 6) ? 7'($urandom) : op_tab[idx];
            ab  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 4)) : -1;
            run_instr(ro, 3'($urandom), 1'($urandom), 1'($urandom), -1, ab, -1, nopin, "");
        end

        exp_valid = 1'b0;
        lit_valid = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
